// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (start, DATA_BITS LSB first,
// optional even/odd parity, 1 or 2 stop bits) behind a valid/ready handshake.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the FSM.
module uart_tx_frame #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    // bit counter also counts stop bits, which never exceed DATA_BITS
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 busy_q;
    logic                 bit_end;
    logic                 start_req;
    logic [DATA_BITS-1:0] load_data;
    logic                 ser_d;
    logic                 done_d;
    logic                 busy_d;

    assign bit_end = (baud_cnt == CNT_W'(DIV - 1));

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic                 full, empty, push, pop;

    assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    // no bypass: a full FIFO refuses the push even in a cycle that pops
    assign push      = tx_valid & ~full;
    assign pop       = (state == IDLE) & ~empty;
    assign tx_ready  = ~full;
    assign start_req = ~empty;
    assign load_data = mem[rd_ptr];
    assign tx_busy   = busy_q | ~empty;

    // FIFO pointers and occupancy; power-of-2 depth wraps the pointers for free
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage, no reset needed since occupancy guards every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end
`else
    assign tx_ready  = (state == IDLE);
    assign start_req = tx_valid;
    assign load_data = tx_data;
    assign tx_busy   = busy_q;
`endif

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_req) state_nxt = START;
            START:  if (bit_end) state_nxt = DATA;
            DATA:   if (bit_end && bit_cnt == BIT_W'(DATA_BITS - 1))
                        state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY: if (bit_end) state_nxt = STOP;
            STOP:   if (bit_end && bit_cnt == BIT_W'(STOP_BITS - 1))
                        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output decode: line level follows the current state one register later
    always_comb begin
        ser_d = 1'b1;
        case (state)
            START:   ser_d = 1'b0;
            DATA:    ser_d = shreg[0];
            PARITY:  ser_d = par_bit;
            default: ser_d = 1'b1;
        endcase
        done_d = (state == STOP) && (state_nxt == IDLE);
        busy_d = (state_nxt != IDLE);
    end

    // state register with the registered outputs; reset forces the line idle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            tx_serial <= 1'b1;
            busy_q    <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_serial <= ser_d;
            busy_q    <= busy_d;
            tx_done   <= done_d;
        end
    end

    // baud/bit counters, shift register and latched parity
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + CNT_W'(1);

            if (state_nxt != state)
                bit_cnt <= '0;
            else if (bit_end && (state == DATA || state == STOP))
                bit_cnt <= bit_cnt + BIT_W'(1);

            if (state == IDLE && start_req) begin
                shreg   <= load_data;
                par_bit <= (^load_data) ^ (PARITY_MODE == 2);
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three DUT configurations at DIV=10, scoreboard of
// accepted words checked bit-exact and cycle-exact on the serial line.
module tb_uart_tx_frame;

    localparam int DIV = 10;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic       vld [3];
    logic [8:0] dat [3];
    logic       rdy [3];
    logic       ser [3];
    logic       bsy [3];
    logic       dn  [3];

    uart_tx_frame #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY_MODE(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .nrst(nrst), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
        .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));

    uart_tx_frame #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY_MODE(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .nrst(nrst), .tx_valid(vld[1]), .tx_data(dat[1][6:0]),
        .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));

    uart_tx_frame #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY_MODE(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .nrst(nrst), .tx_valid(vld[2]), .tx_data(dat[2][7:0]),
        .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

    typedef struct {
        int         d;
        logic [8:0] data;
        logic       par;
        int         acc;
    } exp_t;

    typedef struct {
        logic [8:0] data;
        logic       par;
    } vec_t;

    exp_t sbq [$];
    vec_t tbl [6];

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int last_done = -100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nb(input int d);
        return (d == 1) ? 7 : 8;
    endfunction
    function automatic int pm(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 0;
    endfunction
    function automatic int nst(input int d);
        return (d == 1) ? 2 : 1;
    endfunction
    function automatic int nbits(input int d);
        return 1 + nb(d) + ((pm(d) != 0) ? 1 : 0) + nst(d);
    endfunction

    function automatic void chk(input string nm, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    endfunction

    // drive one word, wait for acceptance, push the expectation
    task automatic send(input int d, input logic [8:0] v, input logic p, input bit keep);
        exp_t e;
        int   t;
        bit   ok;
        t  = 0;
        ok = 0;
        vld[d] = 1'b1;
        dat[d] = v;
        while (!ok && t < 2000) begin
            if (rdy[d]) begin
                e.d = d; e.data = v; e.par = p; e.acc = cyc + 1;
                sbq.push_back(e);
                ok = 1;
            end
            @(negedge clk);
            t++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        if (!keep) vld[d] = 1'b0;
        dat[d] = 9'($urandom);
    endtask

    // wait for a start bit, pop the expectation and check the whole frame
    task automatic check_frame(input int d);
        exp_t        e;
        int          t, s, n, glitch, dcnt, berr, exp_s;
        logic        dlast;
        logic [15:0] ev, got;
        t = 0;
        while (ser[d] !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin chk("start_timeout", t, 0); return; end
        if (sbq.size() == 0) begin chk("sb_empty", 0, 1); return; end
        e = sbq.pop_front();
        s = cyc;
        exp_s = (e.acc + LAT > last_done + 2) ? e.acc + LAT : last_done + 2;
        chk("start_cyc", s, exp_s);
        n  = nbits(d);
        ev = '1;
        ev[0] = 1'b0;
        for (int i = 0; i < nb(d); i++) ev[1 + i] = e.data[i];
        if (pm(d) != 0) ev[1 + nb(d)] = e.par;
        got = '1; glitch = 0; dcnt = 0; berr = 0; dlast = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < DIV; j++) begin
                if (j == DIV / 2) got[k] = ser[d];
                if (ser[d] !== ev[k]) glitch++;
                if (dn[d]) dcnt++;
                if (k == n - 1 && j == DIV - 1) dlast = dn[d];
                else begin
                    if (bsy[d] !== 1'b1) berr++;
                    @(negedge clk);
                end
            end
        end
        last_done = cyc;
        chk("frame_bits", int'(got), int'(ev));
        chk("bit_glitches", glitch, 0);
        chk("done_count", dcnt, 1);
        chk("done_at_end", int'(dlast), 1);
        chk("busy_in_frame", berr, 0);
        @(negedge clk);
        chk("done_width", int'(dn[d]), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        int lows, dsum;
        tbl[0] = '{9'h055, 1'b0};
        tbl[1] = '{9'h001, 1'b1};
        tbl[2] = '{9'h0FF, 1'b0};
        tbl[3] = '{9'h080, 1'b1};
        tbl[4] = '{9'h000, 1'b0};
        tbl[5] = '{9'h0A7, 1'b1};

        nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin vld[i] = 1'b0; dat[i] = '0; end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_serial", int'(ser[i]), 1);
            chk("rst_busy",   int'(bsy[i]), 0);
            chk("rst_done",   int'(dn[i]),  0);
            chk("rst_ready",  int'(rdy[i]), 1);
        end
        nrst = 1'b1;
        @(negedge clk);

        // 8 bits, even parity, 1 stop: table of words with hand-computed parity
        for (int i = 0; i < 6; i++) begin
            fork
                send(0, tbl[i].data, tbl[i].par, 1'b0);
                check_frame(0);
            join
            repeat (3) @(negedge clk);
        end

        // 7 bits, odd parity, 2 stops
        fork
            send(1, 9'h003, 1'b1, 1'b0);
            check_frame(1);
        join
        fork
            send(1, 9'h07F, 1'b0, 1'b0);
            check_frame(1);
        join

        // no parity, tx_valid held across two frames
        fork
            begin
                send(2, 9'h0A5, 1'b0, 1'b1);
                send(2, 9'h03C, 1'b0, 1'b0);
            end
            begin
                check_frame(2);
                check_frame(2);
            end
        join

`ifndef UART_TX_FIFO_EN
        // a pulse while a frame is in DATA is refused and changes nothing
        fork
            send(0, 9'h03C, 1'b0, 1'b0);
            check_frame(0);
            begin
                repeat (35) @(negedge clk);
                vld[0] = 1'b1;
                dat[0] = 9'h0FF;
                chk("busy_ready", int'(rdy[0]), 0);
                @(negedge clk);
                vld[0] = 1'b0;
            end
        join
        lows = 0;
        repeat (30) begin @(negedge clk); if (ser[0] !== 1'b1) lows++; end
        chk("no_extra_frame", lows, 0);
        chk("sb_drained", sbq.size(), 0);
`endif

        // reset in the middle of DATA
        send(1, 9'h02A, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("midrst_serial", int'(ser[1]), 1);
        chk("midrst_busy",   int'(bsy[1]), 0);
        chk("midrst_ready",  int'(rdy[1]), 1);
        sbq.delete();
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        dsum = 0;
        lows = 0;
        repeat (120) begin
            @(negedge clk);
            if (dn[1]) dsum++;
            if (ser[1] !== 1'b1) lows++;
        end
        chk("midrst_no_done", dsum, 0);
        chk("midrst_idle_line", lows, 0);
        fork
            send(1, 9'h055, 1'b1, 1'b0);
            check_frame(1);
        join

`ifdef UART_TX_FIFO_EN
        // five words back-to-back into a 4-deep FIFO
        fork
            begin
                send(0, 9'h011, 1'b0, 1'b1);
                send(0, 9'h022, 1'b0, 1'b1);
                send(0, 9'h07E, 1'b0, 1'b1);
                send(0, 9'h081, 1'b0, 1'b1);
                send(0, 9'h0C4, 1'b1, 1'b0);
                chk("fifo_full_ready", int'(rdy[0]), 0);
                vld[0] = 1'b1;
                dat[0] = 9'h00F;
                @(negedge clk);
                chk("fifo_full_hold", int'(rdy[0]), 0);
                vld[0] = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) check_frame(0);
            end
        join
        chk("fifo_busy_end", int'(bsy[0]), 0);
        lows = 0;
        repeat (30) begin @(negedge clk); if (ser[0] !== 1'b1) lows++; end
        chk("fifo_no_extra", lows, 0);
        chk("fifo_sb_drained", sbq.size(), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
